// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit: a Moore FSM that sequences a shared-memory, single-ALU datapath.
// Optional bne support is enabled by defining MIPS_MC_BNE_EN.

module mips_multicycle_ctrl_chk (
  input logic       clk,
  input logic       rst_n,
  input logic       mem_ready,
  input logic [3:0] state,
  input logic       mem_req,
  input logic       MemWrite,
  input logic       RegWrite,
  input logic       IRWrite,
  input logic       PCEn,
  input logic       illegal_op
);

  a_state_range: assert property (@(posedge clk) disable iff (!rst_n)
    state < 4'd12);

  a_mem_req_state: assert property (@(posedge clk) disable iff (!rst_n)
    mem_req |-> (state == 4'd0 || state == 4'd3 || state == 4'd5));

  a_mem_write_state: assert property (@(posedge clk) disable iff (!rst_n)
    MemWrite |-> (state == 4'd5));

  a_reg_write_state: assert property (@(posedge clk) disable iff (!rst_n)
    RegWrite |-> (state == 4'd4 || state == 4'd7 || state == 4'd10));

  a_ir_write_fetch: assert property (@(posedge clk) disable iff (!rst_n)
    IRWrite |-> (state == 4'd0 && mem_ready));

  a_pc_en_state: assert property (@(posedge clk) disable iff (!rst_n)
    PCEn |-> (state == 4'd0 || state == 4'd8 || state == 4'd11));

  a_illegal_decode: assert property (@(posedge clk) disable iff (!rst_n)
    illegal_op |-> (state == 4'd1));

endmodule

module mips_multicycle_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic [2:0] ALUControl,
  output logic       PCEn,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MIPS_MC_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  // Unknown R-type function codes fall back to add, matching the single-cycle decoder.
  function automatic logic [2:0] funct_to_alu(input logic [5:0] funct);
    case (funct)
      6'b100000: return ALU_ADD;
      6'b100010: return ALU_SUB;
      6'b100100: return ALU_AND;
      6'b100101: return ALU_OR;
      6'b101010: return ALU_SLT;
      default:   return ALU_ADD;
    endcase
  endfunction

  // An opcode that decodes back to FETCH is the illegal-instruction case.
  function automatic state_t decode_next(input logic [5:0] opcode);
    case (opcode)
      OP_LW, OP_SW: return S_MEMADR;
      OP_RTYPE:     return S_RTYPEEX;
      OP_BEQ:       return S_BEQEX;
`ifdef MIPS_MC_BNE_EN
      OP_BNE:       return S_BEQEX;
`endif
      OP_ADDI:      return S_ADDIEX;
      OP_J:         return S_JEX;
      default:      return S_FETCH;
    endcase
  endfunction

  state_t     state_r;
  state_t     next_state_s;
  logic       mem_req_s;
  logic       iord_s;
  logic       mem_write_s;
  logic       ir_write_s;
  logic       reg_dst_s;
  logic       mem_to_reg_s;
  logic       reg_write_s;
  logic       alu_src_a_s;
  logic [1:0] alu_src_b_s;
  logic [1:0] pc_src_s;
  logic [2:0] alu_ctrl_s;
  logic       pc_write_s;
  logic       branch_s;
  logic       illegal_s;
  logic       branch_taken_s;

`ifdef MIPS_MC_BNE_EN
  assign branch_taken_s = (Opcode == OP_BNE) ? ~Zero : Zero;
`else
  assign branch_taken_s = Zero;
`endif

  // State register; reset forces FETCH asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; memory states hold until the memory reports ready.
  always_comb begin
    next_state_s = S_FETCH;
    case (state_r)
      S_FETCH:   next_state_s = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:  next_state_s = decode_next(Opcode);
      S_MEMADR:  next_state_s = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   next_state_s = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:   next_state_s = S_FETCH;
      S_MEMWR:   next_state_s = mem_ready ? S_FETCH : S_MEMWR;
      S_RTYPEEX: next_state_s = S_RTYPEWB;
      S_RTYPEWB: next_state_s = S_FETCH;
      S_BEQEX:   next_state_s = S_FETCH;
      S_ADDIEX:  next_state_s = S_ADDIWB;
      S_ADDIWB:  next_state_s = S_FETCH;
      S_JEX:     next_state_s = S_FETCH;
      default:   next_state_s = S_FETCH;
    endcase
  end

  // Moore output decode; only the FETCH enables look at mem_ready.
  always_comb begin
    mem_req_s    = 1'b0;
    iord_s       = 1'b0;
    mem_write_s  = 1'b0;
    ir_write_s   = 1'b0;
    reg_dst_s    = 1'b0;
    mem_to_reg_s = 1'b0;
    reg_write_s  = 1'b0;
    alu_src_a_s  = 1'b0;
    alu_src_b_s  = SRCB_REG;
    pc_src_s     = PC_ALU;
    alu_ctrl_s   = ALU_ADD;
    pc_write_s   = 1'b0;
    branch_s     = 1'b0;
    illegal_s    = 1'b0;
    case (state_r)
      S_FETCH: begin
        mem_req_s   = 1'b1;
        alu_src_b_s = SRCB_FOUR;
        ir_write_s  = mem_ready;
        pc_write_s  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b_s = SRCB_IMM_SH;
        illegal_s   = (decode_next(Opcode) == S_FETCH);
      end
      S_MEMADR: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = SRCB_IMM;
      end
      S_MEMRD: begin
        iord_s    = 1'b1;
        mem_req_s = 1'b1;
      end
      S_MEMWB: begin
        mem_to_reg_s = 1'b1;
        reg_write_s  = 1'b1;
      end
      S_MEMWR: begin
        iord_s      = 1'b1;
        mem_req_s   = 1'b1;
        mem_write_s = 1'b1;
      end
      S_RTYPEEX: begin
        alu_src_a_s = 1'b1;
        alu_ctrl_s  = funct_to_alu(Funct);
      end
      S_RTYPEWB: begin
        reg_dst_s   = 1'b1;
        reg_write_s = 1'b1;
      end
      S_BEQEX: begin
        alu_src_a_s = 1'b1;
        alu_ctrl_s  = ALU_SUB;
        pc_src_s    = PC_ALUOUT;
        branch_s    = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = SRCB_IMM;
      end
      S_ADDIWB: begin
        reg_write_s = 1'b1;
      end
      S_JEX: begin
        pc_src_s   = PC_JUMP;
        pc_write_s = 1'b1;
      end
      default: begin
        mem_req_s = 1'b0;
      end
    endcase
  end

  // Enables are squashed while reset is low so an aborted instruction writes nothing.
  assign mem_req    = rst_n & mem_req_s;
  assign MemWrite   = rst_n & mem_write_s;
  assign IRWrite    = rst_n & ir_write_s;
  assign RegWrite   = rst_n & reg_write_s;
  assign PCEn       = rst_n & (pc_write_s | (branch_s & branch_taken_s));
  assign illegal_op = rst_n & illegal_s;
  assign IorD       = iord_s;
  assign RegDst     = reg_dst_s;
  assign MemtoReg   = mem_to_reg_s;
  assign ALUSrcA    = alu_src_a_s;
  assign ALUSrcB    = alu_src_b_s;
  assign PCSrc      = pc_src_s;
  assign ALUControl = alu_ctrl_s;
  assign state      = state_r;

  mips_multicycle_ctrl_chk u_chk (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_ready  (mem_ready),
    .state      (state),
    .mem_req    (mem_req),
    .MemWrite   (MemWrite),
    .RegWrite   (RegWrite),
    .IRWrite    (IRWrite),
    .PCEn       (PCEn),
    .illegal_op (illegal_op)
  );

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: instruction-level reference model plus directed literal checks.
// Honors MIPS_MC_BNE_EN the same way the design does.

module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] Opcode = 6'd0;
  logic [5:0] Funct = 6'd0;
  logic       Zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALUControl;
  logic       PCEn, illegal_op;
  logic [3:0] state;

  mips_multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .IorD(IorD), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .ALUControl(ALUControl),
    .PCEn(PCEn), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  typedef enum int {K_LW, K_SW, K_R, K_BEQ, K_BNE, K_ADDI, K_J, K_ILL} kind_e;

  int         n_checks = 0;
  int         n_pass = 0;
  int         m_step = 0;
  kind_e      m_kind = K_ILL;
  logic [5:0] r_opc, r_fn;

  logic [5:0] op_tab [8] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                             6'b001000, 6'b000010, 6'b000101, 6'b111111};
  logic [5:0] fn_tab [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
  logic [3:0] lw_seq [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
  logic       lw_mr  [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [5:0] r_fns  [3] = '{6'b100010, 6'b100100, 6'b101010};
  logic [2:0] r_acs  [3] = '{3'b110, 3'b000, 3'b111};

  function automatic kind_e classify(input logic [5:0] opc);
    case (opc)
      6'b100011: return K_LW;
      6'b101011: return K_SW;
      6'b000000: return K_R;
      6'b000100: return K_BEQ;
      6'b001000: return K_ADDI;
      6'b000010: return K_J;
`ifdef MIPS_MC_BNE_EN
      6'b000101: return K_BNE;
`endif
      default:   return K_ILL;
    endcase
  endfunction

  // Cycles per instruction with no memory stalls.
  function automatic int instr_len(input kind_e k);
    case (k)
      K_LW:               return 5;
      K_SW, K_R, K_ADDI:  return 4;
      K_BEQ, K_BNE, K_J:  return 3;
      default:            return 2;
    endcase
  endfunction

  function automatic logic [2:0] alu_for(input logic [5:0] fn);
    case (fn)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Expected output vector for step `step` of an instruction of kind k.
  function automatic logic [20:0] model_out(input kind_e k, input int step, input logic rst,
                                            input logic mr, input logic z, input logic [5:0] fn);
    logic [3:0] st;
    logic mreq, iord, mw, irw, rdst, m2r, rw, sa, pe, ill;
    logic [1:0] sb, ps;
    logic [2:0] ac;
    st = 4'd0; mreq = 1'b0; iord = 1'b0; mw = 1'b0; irw = 1'b0; rdst = 1'b0;
    m2r = 1'b0; rw = 1'b0; sa = 1'b0; pe = 1'b0; ill = 1'b0;
    sb = 2'b00; ps = 2'b00; ac = 3'b010;
    if (!rst || step == 0) begin
      st = 4'd0; mreq = 1'b1; sb = 2'b01; irw = mr; pe = mr;
    end else if (step == 1) begin
      st = 4'd1; sb = 2'b11; ill = (k == K_ILL);
    end else begin
      case (k)
        K_LW, K_SW: begin
          if (step == 2) begin
            st = 4'd2; sa = 1'b1; sb = 2'b10;
          end else if (k == K_LW && step == 3) begin
            st = 4'd3; iord = 1'b1; mreq = 1'b1;
          end else if (k == K_LW) begin
            st = 4'd4; m2r = 1'b1; rw = 1'b1;
          end else begin
            st = 4'd5; iord = 1'b1; mreq = 1'b1; mw = 1'b1;
          end
        end
        K_R: begin
          if (step == 2) begin
            st = 4'd6; sa = 1'b1; ac = alu_for(fn);
          end else begin
            st = 4'd7; rdst = 1'b1; rw = 1'b1;
          end
        end
        K_BEQ, K_BNE: begin
          st = 4'd8; sa = 1'b1; ac = 3'b110; ps = 2'b01;
          pe = (k == K_BEQ) ? z : ~z;
        end
        K_ADDI: begin
          if (step == 2) begin
            st = 4'd9; sa = 1'b1; sb = 2'b10;
          end else begin
            st = 4'd10; rw = 1'b1;
          end
        end
        K_J: begin
          st = 4'd11; ps = 2'b10; pe = 1'b1;
        end
        default: st = 4'd0;
      endcase
    end
    if (!rst) begin
      mreq = 1'b0; irw = 1'b0; pe = 1'b0;
    end
    return {st, mreq, iord, mw, irw, rdst, m2r, rw, sa, sb, ps, ac, pe, ill};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // One clock: drive on the falling edge, compare the DUT with the model, then advance the model.
  task automatic cycle(input logic rst, input logic [5:0] opc, input logic [5:0] fn,
                       input logic z, input logic mr);
    logic [20:0] exp_v, act_v;
    logic waits;
    @(negedge clk);
    rst_n = rst; Opcode = opc; Funct = fn; Zero = z; mem_ready = mr;
    #1;
    if (!rst_n) m_step = 0;
    if (m_step == 1) m_kind = classify(Opcode);
    exp_v = model_out(m_kind, m_step, rst_n, mem_ready, Zero, Funct);
    act_v = {state, mem_req, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
             ALUSrcB, PCSrc, ALUControl, PCEn, illegal_op};
    check("outputs", 32'(act_v), 32'(exp_v));
    waits = (m_step == 0) || (m_step == 3 && (m_kind == K_LW || m_kind == K_SW));
    if (rst_n && !(waits && !mem_ready)) begin
      m_step++;
      if (m_step >= instr_len(m_kind)) m_step = 0;
    end
  endtask

  initial begin
    // Reset held with memory ready: all enables must stay low.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 6'b100011, 6'd0, 1'b0, 1'b1);
      check("rst_outs", 32'({state, PCEn, IRWrite, mem_req}), 32'd0);
    end

    // lw with two stall cycles in MEMRD.
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 6'b100011, 6'd0, 1'b0, lw_mr[i]);
      check("lw_state", 32'(state), 32'(lw_seq[i]));
      check("lw_wb", 32'(RegWrite & MemtoReg), (i == 6) ? 32'd1 : 32'd0);
      if (i == 0) check("rst_exit", 32'({IRWrite, PCEn}), 32'd3);
    end

    // R-type ALU decode and writeback.
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 6'b000000, r_fns[k], 1'b0, 1'b1);
      cycle(1'b1, 6'b000000, r_fns[k], 1'b0, 1'b1);
      cycle(1'b1, 6'b000000, r_fns[k], 1'b0, 1'b1);
      check("r_state", 32'(state), 32'd6);
      check("r_aluctl", 32'(ALUControl), 32'(r_acs[k]));
      cycle(1'b1, 6'b000000, r_fns[k], 1'b0, 1'b1);
      check("r_wb", 32'({RegWrite, RegDst}), 32'd3);
    end

    // beq taken and not taken, three cycles each.
    for (int z = 1; z >= 0; z--) begin
      cycle(1'b1, 6'b000100, 6'd0, 1'(z), 1'b1);
      cycle(1'b1, 6'b000100, 6'd0, 1'(z), 1'b1);
      cycle(1'b1, 6'b000100, 6'd0, 1'(z), 1'b1);
      check("beq_state", 32'(state), 32'd8);
      check("beq_pcen", 32'(PCEn), 32'(z));
      cycle(1'b1, 6'b000100, 6'd0, 1'(z), 1'b0);
      check("beq_cpi", 32'(state), 32'd0);
    end

    // Illegal opcode: single-cycle pulse in DECODE, no writes.
    cycle(1'b1, 6'b111111, 6'd0, 1'b0, 1'b1);
    cycle(1'b1, 6'b111111, 6'd0, 1'b0, 1'b1);
    check("ill_pulse", 32'({state, illegal_op}), 32'h3);
    check("ill_nowr", 32'({RegWrite, MemWrite}), 32'd0);
    cycle(1'b1, 6'b111111, 6'd0, 1'b0, 1'b0);
    check("ill_end", 32'({state, illegal_op, RegWrite, MemWrite}), 32'd0);

    // sw holding MemWrite through two stalls.
    for (int i = 0; i < 3; i++) cycle(1'b1, 6'b101011, 6'd0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 6'b101011, 6'd0, 1'b0, (i == 2));
      check("sw_write", 32'({state, MemWrite}), 32'h0b);
    end
    cycle(1'b1, 6'b101011, 6'd0, 1'b0, 1'b0);
    check("sw_done", 32'({state, MemWrite}), 32'd0);

    // j: jump target with PC enable.
    for (int i = 0; i < 3; i++) cycle(1'b1, 6'b000010, 6'd0, 1'b0, 1'b1);
    check("j_pc", 32'({state, PCSrc, PCEn}), 32'h5d);

    // bne: branch when Zero is clear, or illegal when the option is off.
    cycle(1'b1, 6'b000101, 6'd0, 1'b0, 1'b1);
    cycle(1'b1, 6'b000101, 6'd0, 1'b0, 1'b1);
`ifdef MIPS_MC_BNE_EN
    check("bne_legal", 32'(illegal_op), 32'd0);
    cycle(1'b1, 6'b000101, 6'd0, 1'b0, 1'b1);
    check("bne_pcen", 32'({state, PCEn}), 32'h11);
`else
    check("bne_illegal", 32'(illegal_op), 32'd1);
    cycle(1'b1, 6'b000101, 6'd0, 1'b0, 1'b0);
    check("bne_ret", 32'(state), 32'd0);
`endif

    // Random instruction stream with stalls, Zero toggling and occasional mid-instruction reset.
    r_opc = 6'b000101;
    r_fn  = 6'd0;
    for (int i = 0; i < 4000; i++) begin
      if (m_step == 0) begin
        int k;
        k = $urandom_range(0, 7);
        r_opc = (k == 7) ? 6'($urandom_range(0, 63)) : op_tab[k];
        r_fn  = fn_tab[$urandom_range(0, 5)];
        if ($urandom_range(0, 5) == 0) r_fn = 6'($urandom_range(0, 63));
      end
      cycle(($urandom_range(0, 79) != 0), r_opc, r_fn, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multicycle control unit for the MIPS core. Replaces the single-cycle combinational decode path with a Moore state machine that sequences a shared-memory, single-ALU datapath over 3–5 cycles per instruction. Internally it decodes `Opcode` and `Funct` to the same 3-bit ALU control codes the single-cycle core uses. It also stalls on a memory ready handshake and produces the gated PC enable.

## Interface
- No parameters.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `Opcode` input 6: instruction register bits [31:26]. Stable from DECODE until the next FETCH completes.
- `Funct` input 6: instruction register bits [5:0].
- `Zero` input 1: ALU zero flag.
- `mem_ready` input 1: memory completes the current access this cycle.
- `mem_req` output 1: memory access request. High in FETCH, MEMRD and MEMWR.
- `IorD`, `MemWrite`, `IRWrite`, `RegDst`, `MemtoReg`, `RegWrite`, `ALUSrcA` output 1 each: datapath selects and enables.
- `ALUSrcB` output 2: 00 reg B, 01 constant 4, 10 sign-extended immediate, 11 immediate shifted left by 2.
- `PCSrc` output 2: 00 ALU result, 01 ALUOut, 10 jump target.
- `ALUControl` output 3: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- `PCEn` output 1: equals `PCWrite | (Branch & branch_taken)`.
- `illegal_op` output 1: one-cycle pulse in DECODE for an unsupported opcode.
- `state` output 4: current state encoding, for debug.

## Operation
- State encodings:
  - 0 FETCH, 1 DECODE, 2 MEMADR, 3 MEMRD, 4 MEMWB, 5 MEMWR
  - 6 RTYPEEX, 7 RTYPEWB, 8 BEQEX, 9 ADDIEX, 10 ADDIWB, 11 JEX
  - 12–15 unused; they return to FETCH on the next edge.
- FETCH:
  - Drives `IorD`=0, `ALUSrcA`=0, `ALUSrcB`=01, add, `PCSrc`=00, `mem_req`=1.
  - `IRWrite` and `PCWrite` are asserted only in the cycle where `mem_ready`=1; that cycle transitions to DECODE. Otherwise the FSM holds in FETCH.
- DECODE:
  - Drives `ALUSrcA`=0, `ALUSrcB`=11, add (branch target into ALUOut).
  - Next state by opcode:
    - lw 100011 or sw 101011 → MEMADR
    - R-type 000000 → RTYPEEX
    - beq 000100 → BEQEX
    - addi 001000 → ADDIEX
    - j 000010 → JEX
    - anything else → FETCH, with `illegal_op`=1
- MEMADR: `ALUSrcA`=1, `ALUSrcB`=10, add. lw → MEMRD; sw → MEMWR.
- MEMRD: `IorD`=1, `mem_req`=1. Holds until `mem_ready`, then goes to MEMWB.
- MEMWB: `RegDst`=0, `MemtoReg`=1, `RegWrite`=1 → FETCH.
- MEMWR: `IorD`=1, `mem_req`=1, `MemWrite`=1 on every cycle in the state. Holds until `mem_ready`, then goes to FETCH.
- RTYPEEX: `ALUSrcA`=1, `ALUSrcB`=00, ALU control from Funct → RTYPEWB.
  - Funct decode: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt; any other value → 010.
- RTYPEWB: `RegDst`=1, `MemtoReg`=0, `RegWrite`=1 → FETCH.
- BEQEX: `ALUSrcA`=1, `ALUSrcB`=00, sub, `PCSrc`=01, `Branch`=1 → FETCH. Branch is taken when `Zero`=1.
- ADDIEX: `ALUSrcA`=1, `ALUSrcB`=10, add → ADDIWB.
- ADDIWB: `RegDst`=0, `MemtoReg`=0, `RegWrite`=1 → FETCH.
- JEX: `PCSrc`=10, `PCWrite`=1 → FETCH.
- Any output not listed for a state is 0 in that state (ALU control defaults to 010).

## Timing
- All outputs are combinational from `state`. `IRWrite`, `PCWrite` in FETCH and `PCEn` in BEQEX also depend on `mem_ready` or `Zero` in the same cycle.
- Reset behaviour:
  - While `rst_n`=0, `state` is forced to FETCH.
  - All enables (`IRWrite`, `PCEn`, `RegWrite`, `MemWrite`, `mem_req`) are forced to 0.
  - The FSM leaves reset in FETCH on the first edge after deassertion.
  - Reset asserted mid-instruction aborts the instruction immediately, with no partial write after the assertion.
- Cycles per instruction with `mem_ready` held at 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Each cycle of `mem_ready`=0 in FETCH, MEMRD or MEMWR adds exactly one cycle. All outputs stay stable while the FSM holds.

## Configuration
- Macro: `MIPS_MC_BNE_EN`.
- Defined:
  - Opcode 000101 (bne) in DECODE → BEQEX, with no `illegal_op`.
  - In BEQEX the branch is taken when `Zero` equals 1 for beq and 0 for bne.
- Undefined: opcode 000101 is illegal (`illegal_op` pulse, return to FETCH).

## Test plan
- **Reset:** hold `rst_n`=0 for 3 cycles with `mem_ready`=1 → `state`=0, `PCEn`=0, `IRWrite`=0, `mem_req`=0. After release, the first cycle shows `IRWrite`=1 and `PCEn`=1.
- **lw with stall:** opcode 100011, `mem_ready`=0 for 2 cycles in MEMRD → state sequence 0,1,2,3,3,3,4,0. `RegWrite`=1 with `MemtoReg`=1 only in state 4.
- **R-type decode:** funct 100010, 100100, 101010 → `ALUControl` 110, 000, 111 in RTYPEEX, then `RegWrite`=1 with `RegDst`=1.
- **beq:** `Zero`=1 → `PCEn`=1 in BEQEX. `Zero`=0 → `PCEn`=0. Both take 3 cycles total.
- **Illegal opcode:** opcode 111111 → `illegal_op`=1 for exactly one cycle in DECODE, then FETCH. No `RegWrite` or `MemWrite` is asserted.
- **sw, j and bne:**
  - sw: `MemWrite`=1 through 2 stall cycles.
  - j: `PCSrc`=10 with `PCEn`=1.
  - With `MIPS_MC_BNE_EN` defined, opcode 000101 and `Zero`=0 give `PCEn`=1.
